// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared display definitions. These are the digit code type and
//                the code the seven-seg decoder renders as a dark digit.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Reference digit width that the shared digit type is built on.
    localparam int DISPLAY_DIGIT_W = 4;

    typedef logic [DISPLAY_DIGIT_W-1:0] digit_t;

    // Decoder input code that leaves every segment unlit.
    localparam digit_t BLANK_CODE = 4'd11;

endpackage : display_pkg
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
//  Module      : scan_timer
//  Description : Digit-slot prescaler and digit index counter for the scanned
//                display. The prescaler counts 0..SCAN_DIV-1. When it wraps,
//                the index moves to the next digit and goes from NUM_DIGITS-1
//                back to 0.
//  Ports       : clk        in  system clock, rising edge
//                reset      in  synchronous, active-high
//                slot_end   out last cycle of the current digit slot
//                index      out digit currently being scanned
//                frame_end  out last cycle of the last slot of a frame
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_timer #(
    parameter  int NUM_DIGITS = 4,
    parameter  int SCAN_DIV   = 1000,
    localparam int SEL_W      = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             slot_end,
    output logic [SEL_W-1:0] index,
    output logic             frame_end
);

    localparam int               c_pre_w    = $clog2(SCAN_DIV);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0]   c_idx_last = SEL_W'(NUM_DIGITS - 1);

    logic [c_pre_w-1:0] r_presc;
    logic [SEL_W-1:0]   r_index;

    assign slot_end  = (r_presc == c_pre_last);
    assign frame_end = slot_end && (r_index == c_idx_last);
    assign index     = r_index;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_index <= '0;
        end else begin
            if (slot_end) begin
                r_presc <= '0;
                // Wrap explicitly so that a non-power-of-two digit count
                // never reaches an unused index.
                if (r_index == c_idx_last) begin
                    r_index <= '0;
                end else begin
                    r_index <= r_index + SEL_W'(1);
                end
            end else begin
                r_presc <= r_presc + c_pre_w'(1);
            end
        end
    end

endmodule : scan_timer
`default_nettype wire

// File: rtl/digit_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : digit_scan_mux
//  Description : Holds NUM_DIGITS BCD digits in double-buffered registers and
//                time-multiplexes them onto one seven-seg decoder input. It
//                can blank leading zeros and blink the whole display.
//  Ports       : clk          in  system clock, rising edge
//                reset        in  synchronous, active-high
//                load_valid   in  writer offers a new digit set
//                load_ready   out pending buffer is free
//                load_digits  in  digit i at [i*DIGIT_W +: DIGIT_W]
//                lz_blank_en  in  1 = blank leading zeros
//                blink_en     in  1 = blink whole display
//                digit_sel    out index of the digit now shown
//                digit_en     out one-hot digit enable (bit digit_sel)
//                digit_val    out code to decoder, BLANK_CODE = dark
//                frame_tick   out one-cycle pulse after each full scan
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_scan_mux
    import display_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int DIGIT_W      = 4,
    parameter  int SCAN_DIV     = 1000,
    parameter  int BLINK_FRAMES = 64,
    localparam int SEL_W        = $clog2(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_digits,
    input  logic                          lz_blank_en,
    input  logic                          blink_en,
    output logic [SEL_W-1:0]              digit_sel,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic [DIGIT_W-1:0]            digit_val,
    output logic                          frame_tick
);

    localparam logic [DIGIT_W-1:0]    c_blank       = DIGIT_W'(BLANK_CODE);
    localparam logic [NUM_DIGITS-1:0] c_en_base     = NUM_DIGITS'(1);
    localparam int                    c_blk_w       = $clog2(BLINK_FRAMES) + 1;
    localparam logic [c_blk_w-1:0]    c_frames_last = c_blk_w'(BLINK_FRAMES - 1);

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    logic             w_slot_end;
    logic             w_frame_end;
    logic [SEL_W-1:0] w_index;
    logic             w_wrap;

    scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV)
    ) u_scan_timer (
        .clk       (clk),
        .reset     (reset),
        .slot_end  (w_slot_end),
        .index     (w_index),
        .frame_end (w_frame_end)
    );

    // The frame boundary is the slot_end that sends the index back to 0. Every
    // frame-aligned action (commit, blink count, frame_tick) uses this strobe.
    assign w_wrap = w_slot_end & w_frame_end;

    // ------------------------------------------------------------------
    // Double buffer. The writer fills pending. Pending moves to active only
    // at a frame boundary, so no frame ever shows a mix of two sets.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS*DIGIT_W-1:0] r_active;
    logic [NUM_DIGITS*DIGIT_W-1:0] r_pending;
    logic                          r_pending_vld;
    logic                          w_xfer;

    assign load_ready = ~r_pending_vld;
    assign w_xfer     = load_valid & ~r_pending_vld;

    // Commit needs pending_vld=1 and transfer needs pending_vld=0, so the
    // two branches never fire in the same cycle. A transfer on the wrap
    // cycle therefore waits in pending for the next frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active      <= {NUM_DIGITS{c_blank}};
            r_pending     <= {NUM_DIGITS{c_blank}};
            r_pending_vld <= 1'b0;
        end else begin
            if (w_wrap && r_pending_vld) begin
                r_active      <= r_pending;
                r_pending_vld <= 1'b0;
            end
            if (w_xfer) begin
                r_pending     <= load_digits;
                r_pending_vld <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Blink phase. The counter always runs, so the blink cadence stays
    // aligned even while blink_en is low.
    // ------------------------------------------------------------------
    logic [c_blk_w-1:0] r_frame_cnt;
    logic               r_phase_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (w_wrap) begin
            if (r_frame_cnt == c_frames_last) begin
                r_frame_cnt <= '0;
                r_phase_on  <= ~r_phase_on;
            end else begin
                r_frame_cnt <= r_frame_cnt + c_blk_w'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero mask. Walk from the most significant digit down while
    // every digit seen so far is zero or already dark. Digit 0 is never
    // masked, so an all-zero value still reads "0".
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] w_lz_mask;
    logic                  w_lz_run;
    logic [DIGIT_W-1:0]    w_lz_digit;

    always_comb begin
        w_lz_mask  = '0;
        w_lz_run   = 1'b1;
        w_lz_digit = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_lz_digit = r_active[i*DIGIT_W +: DIGIT_W];
            w_lz_run   = w_lz_run & ((w_lz_digit == '0) | (w_lz_digit == c_blank));
            if (i != 0) begin
                w_lz_mask[i] = w_lz_run;
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit select and blanking priority:
    //   blink-off > leading-zero blank > active digit
    // ------------------------------------------------------------------
    logic [DIGIT_W-1:0] w_cur_digit;
    logic               w_cur_lz;
    logic [DIGIT_W-1:0] w_next_val;

    always_comb begin
        w_cur_digit = c_blank;
        w_cur_lz    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_index == SEL_W'(i)) begin
                w_cur_digit = r_active[i*DIGIT_W +: DIGIT_W];
                w_cur_lz    = w_lz_mask[i];
            end
        end
        w_next_val = w_cur_digit;
        if (blink_en && !r_phase_on) begin
            w_next_val = c_blank;
        end else if (lz_blank_en && w_cur_lz) begin
            w_next_val = c_blank;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs. They follow the scan index one cycle later.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_sel  <= '0;
            digit_en   <= '0;
            digit_val  <= c_blank;
            frame_tick <= 1'b0;
        end else begin
            digit_sel  <= w_index;
            digit_en   <= c_en_base << w_index;
            digit_val  <= w_next_val;
            frame_tick <= w_wrap;
        end
    end

endmodule : digit_scan_mux
`default_nettype wire

// File: tb/tb_digit_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_digit_scan_mux
//  Description : Directed self-checking bench for digit_scan_mux with
//                NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_scan_mux;

    localparam logic [3:0]  c_b    = 4'd11;
    localparam logic [15:0] c_dark = 16'hBBBB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_digits = '0;
    logic        lz_blank_en = 1'b0;
    logic        blink_en = 1'b0;
    logic [1:0]  digit_sel;
    logic [3:0]  digit_en;
    logic [3:0]  digit_val;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    digit_scan_mux #(
        .NUM_DIGITS   (4),
        .DIGIT_W      (4),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_digits (load_digits),
        .lz_blank_en (lz_blank_en),
        .blink_en    (blink_en),
        .digit_sel   (digit_sel),
        .digit_en    (digit_en),
        .digit_val   (digit_val),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait for the next frame_tick. The task returns at that negedge.
    task automatic wait_tick(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // Call this at a frame_tick negedge. It samples the following 16 cycles
    // (one output frame) and packs the value of each slot in load format.
    // ok drops if a slot shows the wrong sel/en or its value changes within
    // the slot.
    task automatic capture(output logic [15:0] vals, output bit ok);
        logic [3:0] v;
        logic [3:0] en_exp;
        ok   = 1'b1;
        vals = '0;
        v    = '0;
        for (int s = 0; s < 4; s++) begin
            en_exp = 4'b0001 << s;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (digit_sel !== 2'(s) || digit_en !== en_exp) ok = 1'b0;
                if (c == 0) v = digit_val;
                else if (digit_val !== v) ok = 1'b0;
            end
            vals[s*4 +: 4] = v;
        end
    endtask

    // Start a load at a negedge. The transfer completes on the next posedge
    // at which load_ready is high.
    task automatic do_load(input logic [15:0] d, output bit timed_out);
        load_digits = d;
        load_valid  = 1'b1;
        timed_out   = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (load_ready) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (!timed_out) begin
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({digit_sel, digit_en, digit_val, frame_tick, load_ready} !==
            {2'd0, 4'b0000, c_b, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: sel=%0d en=%b val=%0d tick=%b rdy=%b, want sel=0 en=0000 val=11 tick=0 rdy=1",
                     digit_sel, digit_en, digit_val, frame_tick, load_ready);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (digit_en !== 4'b0000) begin
            n_fail++;
            $display("FAIL first_cycle_en: got %b, want 0000", digit_en);
        end
    endtask

    // Starts in cycle 0 right after reset release. Output cycle k shows
    // index (k-1)/4 and frame_tick fires on cycles 16, 32, ...
    task automatic test_scan();
        logic [1:0] es;
        logic [3:0] ee;
        logic       et;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            es = 2'(((k - 1) / 4) % 4);
            ee = 4'b0001 << es;
            et = (k % 16) == 0;
            n_tests++;
            if ({digit_sel, digit_en, digit_val, frame_tick} !== {es, ee, c_b, et}) begin
                n_fail++;
                $display("FAIL scan_cycle_%0d: sel=%0d en=%b val=%0d tick=%b, want sel=%0d en=%b val=11 tick=%b",
                         k, digit_sel, digit_en, digit_val, frame_tick, es, ee, et);
            end
        end
    endtask

    task automatic test_lz_blank();
        bit to;
        bit ok;
        logic [15:0] vals;
        lz_blank_en = 1'b1;
        wait_tick(to);
        do_load(16'h0042, to);
        wait_tick(to);
        capture(vals, ok);
        n_tests++;
        if (to || !ok || vals !== 16'hBB42) begin
            n_fail++;
            $display("FAIL lz_0042: got %h ok=%0b to=%0b, want bb42", vals, ok, to);
        end
        n_tests++;
        if (load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_commit: got %b, want 1", load_ready);
        end
    endtask

    task automatic test_all_zero();
        bit to;
        bit ok;
        logic [15:0] vals;
        lz_blank_en = 1'b1;
        wait_tick(to);
        do_load(16'h0000, to);
        wait_tick(to);
        capture(vals, ok);
        n_tests++;
        if (to || !ok || vals !== 16'hBBB0) begin
            n_fail++;
            $display("FAIL zero_lz_on: got %h ok=%0b to=%0b, want bbb0", vals, ok, to);
        end
        lz_blank_en = 1'b0;
        capture(vals, ok);
        n_tests++;
        if (!ok || vals !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_lz_off: got %h ok=%0b, want 0000", vals, ok);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        bit ok;
        int waits;
        logic [15:0] vals;
        lz_blank_en = 1'b0;
        wait_tick(to);
        load_digits = 16'h1234;
        load_valid  = 1'b1;
        n_tests++;
        if (to || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_ready: got %b to=%0b, want 1", load_ready, to);
        end
        @(posedge clk);
        #1;
        load_digits = 16'h5678;
        waits = 0;
        @(negedge clk);
        while (!load_ready && waits < 64) begin
            waits++;
            @(negedge clk);
        end
        // The pending set commits at the wrap edge ending cycle T+15, so
        // ready stays low on cycles T+1..T+15.
        n_tests++;
        if (waits != 15) begin
            n_fail++;
            $display("FAIL b2b_ready_low_cycles: got %0d, want 15", waits);
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        capture(vals, ok);
        n_tests++;
        if (!ok || vals !== 16'h1234) begin
            n_fail++;
            $display("FAIL b2b_set1: got %h ok=%0b, want 1234", vals, ok);
        end
        capture(vals, ok);
        n_tests++;
        if (!ok || vals !== 16'h5678) begin
            n_fail++;
            $display("FAIL b2b_set2: got %h ok=%0b, want 5678", vals, ok);
        end
    endtask

    task automatic test_wrap_load();
        bit to;
        bit ok;
        logic [15:0] vals;
        wait_tick(to);
        repeat (15) @(negedge clk);
        // Cycle T+15 is the wrapping slot_end. Transfer exactly on it.
        load_digits = 16'h9087;
        load_valid  = 1'b1;
        n_tests++;
        if (to || load_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_ready: got %b to=%0b, want 1", load_ready, to);
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (frame_tick !== 1'b1 || load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_tick_pending: tick=%b rdy=%b, want tick=1 rdy=0", frame_tick, load_ready);
        end
        capture(vals, ok);
        n_tests++;
        if (!ok || vals !== 16'h5678) begin
            n_fail++;
            $display("FAIL wrap_next_frame_old: got %h ok=%0b, want 5678", vals, ok);
        end
        capture(vals, ok);
        n_tests++;
        if (!ok || vals !== 16'h9087) begin
            n_fail++;
            $display("FAIL wrap_frame_after_next: got %h ok=%0b, want 9087", vals, ok);
        end
    endtask

    task automatic test_reset_and_blink();
        bit to;
        bit ok;
        int n;
        logic [15:0] vals;
        logic [15:0] exp_seq [5];
        exp_seq = '{16'h3105, c_dark, c_dark, 16'h3105, 16'h3105};
        wait_tick(to);
        do_load(16'h7777, to);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({digit_sel, digit_en, digit_val, frame_tick, load_ready} !==
            {2'd0, 4'b0000, c_b, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL midframe_reset: sel=%0d en=%b val=%0d tick=%b rdy=%b, want sel=0 en=0000 val=11 tick=0 rdy=1",
                     digit_sel, digit_en, digit_val, frame_tick, load_ready);
        end
        reset       = 1'b0;
        blink_en    = 1'b1;
        lz_blank_en = 1'b0;
        load_digits = 16'h3105;
        load_valid  = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        n = 0;
        while (n < 64) begin
            @(negedge clk);
            n++;
            if (frame_tick) break;
        end
        n_tests++;
        if (n != 16) begin
            n_fail++;
            $display("FAIL first_tick_after_reset: got cycle %0d, want 16", n);
        end
        // Phase flips at every second frame boundary: on, off, off, on, on.
        for (int f = 0; f < 5; f++) begin
            capture(vals, ok);
            n_tests++;
            if (!ok || vals !== exp_seq[f]) begin
                n_fail++;
                $display("FAIL blink_frame_%0d: got %h ok=%0b, want %h", f, vals, ok, exp_seq[f]);
            end
        end
        // Off-phase frame, but blink disabled -> digits shown.
        blink_en = 1'b0;
        capture(vals, ok);
        n_tests++;
        if (!ok || vals !== 16'h3105) begin
            n_fail++;
            $display("FAIL blink_disabled: got %h ok=%0b, want 3105", vals, ok);
        end
        // Counter kept running: still in the off half-period.
        blink_en = 1'b1;
        capture(vals, ok);
        n_tests++;
        if (!ok || vals !== c_dark) begin
            n_fail++;
            $display("FAIL blink_reenabled: got %h ok=%0b, want bbbb", vals, ok);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz_blank();
        test_all_zero();
        test_back_to_back();
        test_wrap_load();
        test_reset_and_blink();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_digit_scan_mux
`default_nettype wire
